param_menu: RTL and testbench

- Generalised front-panel parameter menu for the display pipeline; successor to the fixed 5-entry selector.
- Manages NUM_PARAMS independent parameters, each with its own wrap limit. Driven by four debounced buttons: up, down, next and set.
- Supports a browse/edit split, a staged value with explicit commit, hold-to-auto-repeat, and an edit timeout that cancels the edit.
- Feeds the display and scale logic through a packed value bus.

---
 rtl/param_menu_pkg.sv | 36 +++
 rtl/param_menu_btn_repeat.sv | 36 +++
 rtl/param_menu.sv | 191 +++++++++++++++++++
 tb/tb_param_menu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_menu_pkg.sv
// Shared types, default timing constants and wrap helpers for the front-panel parameter menu.
package param_menu_pkg;

  typedef enum logic [1:0] {
    ST_BROWSE      = 2'd0,
    ST_BROWSE_HOLD = 2'd1,
    ST_EDIT        = 2'd2,
    ST_EDIT_HOLD   = 2'd3
  } menu_state_t;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_UP   = 3'd1,
    BTN_DOWN = 3'd2,
    BTN_NEXT = 3'd3,
    BTN_SET  = 3'd4
  } btn_sel_t;

  localparam int DEF_HOLD_CYCLES    = 32_500_000;
  localparam int DEF_REPEAT_CYCLES  = 6_500_000;
  localparam int DEF_TIMEOUT_CYCLES = 650_000_000;

  // Helpers work on a fixed 8-bit width; callers zero-extend and truncate.
  localparam int FN_W = 8;

  function automatic logic [FN_W-1:0] wrap_inc(input logic [FN_W-1:0] value,
                                               input logic [FN_W-1:0] max_val);
    return (value >= max_val) ? '0 : value + 8'd1;
  endfunction

  function automatic logic [FN_W-1:0] wrap_dec(input logic [FN_W-1:0] value,
                                               input logic [FN_W-1:0] max_val);
    return (value == '0) ? max_val : value - 8'd1;
  endfunction

endpackage

// File: rtl/param_menu_btn_repeat.sv
// Hold-to-auto-repeat timer: one step on the first held cycle, another after
// HOLD_CYCLES, then one every REPEAT_CYCLES while the button stays held.
module btn_repeat #(
  parameter int HOLD_CYCLES   = 32_500_000,
  parameter int REPEAT_CYCLES = 6_500_000
) (
  input  logic clk_65mhz,
  input  logic held_i,
  input  logic clear_i,
  output logic step_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q;
  logic [REP_W-1:0]  rep_q;

  // hold_q saturates at HOLD_CYCLES; from then on rep_q paces the repeats.
  always_ff @(posedge clk_65mhz) begin
    if (clear_i || !held_i) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (hold_q != HOLD_W'(HOLD_CYCLES)) begin
      hold_q <= hold_q + 1'b1;
    end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end

  assign step_o = held_i && !clear_i &&
                  ((hold_q == '0) || ((hold_q == HOLD_W'(HOLD_CYCLES)) && (rep_q == '0)));

endmodule

// File: rtl/param_menu.sv
// Front-panel parameter menu: browse/edit FSM with staged value, commit, auto-repeat and edit timeout.
// Optional LIVE_PREVIEW_EN: the selected values slice shows the staged value while editing.
module param_menu
  import param_menu_pkg::*;
#(
  parameter int NUM_PARAMS = 5,
  parameter int VAL_W      = 3,
  parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MAX = {3'd2, 3'd4, 3'd1, 3'd1, 3'd3},
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk_65mhz,
  input  logic                          rst,
  input  logic                          up,
  input  logic                          down,
  input  logic                          next,
  input  logic                          set,
  output logic [NUM_PARAMS*VAL_W-1:0]   values,
  output logic [$clog2(NUM_PARAMS)-1:0] selector_val,
  output logic [VAL_W-1:0]              staged_val,
  output logic                          editing,
  output logic                          commit,
  output logic [1:0]                    button_state
);

  localparam int SEL_W = $clog2(NUM_PARAMS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  menu_state_t        state_q;
  btn_sel_t           btn_q;
  logic [SEL_W-1:0]   sel_q;
  logic [VAL_W-1:0]   staged_q;
  logic [VAL_W-1:0]   vals_q [NUM_PARAMS];
  logic [VAL_W-1:0]   max_tbl [NUM_PARAMS];
  logic [TO_W-1:0]    to_q;
  logic               editing_q;
  logic               commit_q;

  logic               btn_lvl_d;
  logic               held_d;
  logic               dir_up_d;
  logic               step_d;
  logic [VAL_W-1:0]   stepped_d;
  logic [FN_W-1:0]    cur_w;
  logic [FN_W-1:0]    max_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_max
      assign max_tbl[gi] = PARAM_MAX[gi*VAL_W +: VAL_W];
    end
  endgenerate

  always_comb begin
    btn_lvl_d = 1'b0;
    case (btn_q)
      BTN_UP:   btn_lvl_d = up;
      BTN_DOWN: btn_lvl_d = down;
      BTN_NEXT: btn_lvl_d = next;
      BTN_SET:  btn_lvl_d = set;
      default:  btn_lvl_d = 1'b0;
    endcase
  end

  // The repeat timer sees a fresh up/down press in EDIT, then the latched level in EDIT_HOLD.
  always_comb begin
    held_d   = 1'b0;
    dir_up_d = 1'b1;
    if (state_q == ST_EDIT && btn_q == BTN_NONE) begin
      held_d   = up | down;
      dir_up_d = up;
    end else if (state_q == ST_EDIT_HOLD) begin
      held_d   = btn_lvl_d;
      dir_up_d = (btn_q == BTN_UP);
    end
  end

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_repeat (
    .clk_65mhz(clk_65mhz),
    .held_i   (held_d),
    .clear_i  (rst),
    .step_o   (step_d)
  );

  assign cur_w     = FN_W'(staged_q);
  assign max_w     = FN_W'(max_tbl[sel_q]);
  assign stepped_d = dir_up_d ? VAL_W'(wrap_inc(cur_w, max_w)) : VAL_W'(wrap_dec(cur_w, max_w));

  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      state_q   <= ST_BROWSE;
      btn_q     <= BTN_NONE;
      sel_q     <= '0;
      staged_q  <= '0;
      to_q      <= '0;
      editing_q <= 1'b0;
      commit_q  <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) vals_q[i] <= '0;
    end else begin
      commit_q <= 1'b0;
      if (step_d) staged_q <= stepped_d;
      case (state_q)
        ST_BROWSE: begin
          if (up)        begin btn_q <= BTN_UP;   state_q <= ST_BROWSE_HOLD; end
          else if (down) begin btn_q <= BTN_DOWN; state_q <= ST_BROWSE_HOLD; end
          else if (next) begin btn_q <= BTN_NEXT; state_q <= ST_BROWSE_HOLD; end
          else if (set)  begin btn_q <= BTN_SET;  state_q <= ST_BROWSE_HOLD; end
        end
        ST_BROWSE_HOLD: begin
          if (!btn_lvl_d) begin
            btn_q   <= BTN_NONE;
            state_q <= ST_BROWSE;
            case (btn_q)
              BTN_UP:   sel_q <= (sel_q == SEL_W'(NUM_PARAMS - 1)) ? '0 : sel_q + 1'b1;
              BTN_DOWN: sel_q <= (sel_q == '0) ? SEL_W'(NUM_PARAMS - 1) : sel_q - 1'b1;
              BTN_NEXT: begin
                staged_q  <= vals_q[sel_q];
                state_q   <= ST_EDIT;
                editing_q <= 1'b1;
                to_q      <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_EDIT: begin
          if (btn_q != BTN_NONE) begin
            // set/next latched: act on release, leaving edit either way.
            if (!btn_lvl_d) begin
              if (btn_q == BTN_SET) begin
                vals_q[sel_q] <= staged_q;
                commit_q      <= 1'b1;
              end
              state_q   <= ST_BROWSE;
              btn_q     <= BTN_NONE;
              staged_q  <= '0;
              editing_q <= 1'b0;
            end
          end else if (up || down) begin
            btn_q   <= up ? BTN_UP : BTN_DOWN;
            state_q <= ST_EDIT_HOLD;
            to_q    <= '0;
          end else if (set) begin
            btn_q <= BTN_SET;
            to_q  <= '0;
          end else if (next) begin
            btn_q <= BTN_NEXT;
            to_q  <= '0;
          end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ST_BROWSE;
            staged_q  <= '0;
            editing_q <= 1'b0;
            to_q      <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_EDIT_HOLD: begin
          if (!btn_lvl_d) begin
            state_q <= ST_EDIT;
            btn_q   <= BTN_NONE;
            to_q    <= '0;
          end
        end
        default: state_q <= ST_BROWSE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_out
`ifdef LIVE_PREVIEW_EN
      assign values[gi*VAL_W +: VAL_W] =
        (editing_q && (sel_q == SEL_W'(gi))) ? staged_q : vals_q[gi];
`else
      assign values[gi*VAL_W +: VAL_W] = vals_q[gi];
`endif
    end
  endgenerate

  assign selector_val = sel_q;
  assign staged_val   = staged_q;
  assign editing      = editing_q;
  assign commit       = commit_q;
  assign button_state = state_q;

endmodule

// File: tb/tb_param_menu.sv
// Self-checking bench for param_menu: cycle-level behavioural model plus directed literal checks.
module tb_param_menu;

  localparam int N  = 5;
  localparam int VW = 3;
  localparam int H  = 8;
  localparam int R  = 4;
  localparam int T  = 50;
  localparam logic [N*VW-1:0] PMAX = {3'd2, 3'd4, 3'd1, 3'd1, 3'd3};

  int pmax [N] = '{3, 1, 1, 4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_up = 1'b0, b_down = 1'b0, b_next = 1'b0, b_set = 1'b0;
  logic [N*VW-1:0] values;
  logic [2:0]      selector_val;
  logic [VW-1:0]   staged_val;
  logic            editing;
  logic            commit;
  logic [1:0]      button_state;

  always #5 clk = ~clk;

  param_menu #(
    .NUM_PARAMS(N), .VAL_W(VW), .PARAM_MAX(PMAX),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_65mhz(clk), .rst(rst),
    .up(b_up), .down(b_down), .next(b_next), .set(b_set),
    .values(values), .selector_val(selector_val), .staged_val(staged_val),
    .editing(editing), .commit(commit), .button_state(button_state)
  );

  int total = 0;
  int bad = 0;
  int commits = 0;
  bit checking = 0;

  // Model state: mode 0 browse, 1 browse-hold, 2 edit, 3 edit-hold; button 0 up,1 down,2 next,3 set,-1 none.
  int m_mode = 0, m_sel = 0, m_staged = 0, m_commit = 0, m_btn = -1, m_idle = 0, m_hold = 0;
  int m_val [N] = '{0, 0, 0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int btn_level(input int b);
    case (b)
      0: return int'(b_up);
      1: return int'(b_down);
      2: return int'(b_next);
      3: return int'(b_set);
      default: return 0;
    endcase
  endfunction

  function automatic int bump(input int v, input int mx, input bit go_up);
    return go_up ? (v + 1) % (mx + 1) : (v + mx) % (mx + 1);
  endfunction

  function automatic logic [N*VW-1:0] exp_values();
    logic [N*VW-1:0] v;
    int slice;
    v = '0;
    for (int i = 0; i < N; i++) begin
      slice = m_val[i];
`ifdef LIVE_PREVIEW_EN
      if (m_mode >= 2 && i == m_sel) slice = m_staged;
`endif
      v[i*VW +: VW] = VW'(slice);
    end
    return v;
  endfunction

  task automatic model_step();
    int lv;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_staged = 0; m_commit = 0; m_btn = -1; m_idle = 0; m_hold = 0;
      for (int i = 0; i < N; i++) m_val[i] = 0;
      return;
    end
    m_commit = 0;
    lv = (m_btn >= 0) ? btn_level(m_btn) : 0;
    case (m_mode)
      0: begin
        m_btn = b_up ? 0 : b_down ? 1 : b_next ? 2 : b_set ? 3 : -1;
        if (m_btn >= 0) m_mode = 1;
      end
      1: if (lv == 0) begin
        m_mode = 0;
        if (m_btn == 0) m_sel = (m_sel + 1) % N;
        else if (m_btn == 1) m_sel = (m_sel + N - 1) % N;
        else if (m_btn == 2) begin m_staged = m_val[m_sel]; m_mode = 2; m_idle = 0; end
        m_btn = -1;
      end
      2: begin
        if (m_btn >= 0) begin
          if (lv == 0) begin
            if (m_btn == 3) begin m_val[m_sel] = m_staged; m_commit = 1; end
            m_mode = 0; m_staged = 0; m_btn = -1;
          end
        end else if (b_up || b_down) begin
          m_btn = b_up ? 0 : 1;
          m_staged = bump(m_staged, pmax[m_sel], b_up);
          m_hold = 1; m_mode = 3; m_idle = 0;
        end else if (b_set) begin
          m_btn = 3; m_idle = 0;
        end else if (b_next) begin
          m_btn = 2; m_idle = 0;
        end else if (m_idle == T - 1) begin
          m_mode = 0; m_staged = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      3: begin
        if (lv != 0) begin
          if (m_hold >= H && (m_hold - H) % R == 0) m_staged = bump(m_staged, pmax[m_sel], m_btn == 0);
          m_hold++;
        end else begin
          m_mode = 2; m_btn = -1; m_idle = 0;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("values", 32'(values), 32'(exp_values()));
      chk("selector_val", 32'(selector_val), 32'(m_sel));
      chk("staged_val", 32'(staged_val), 32'(m_staged));
      chk("editing", 32'(editing), (m_mode >= 2) ? 32'd1 : 32'd0);
      chk("commit", 32'(commit), 32'(m_commit));
      chk("button_state", 32'(button_state), 32'(m_mode));
      if (commit === 1'b1) commits++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: b_up = v;
      1: b_down = v;
      2: b_next = v;
      default: b_set = v;
    endcase
  endtask

  task automatic tap(input int b, input int hold);
    set_btn(b, 1'b1);
    tick(hold);
    set_btn(b, 1'b0);
    tick(2);
  endtask

  int seq3 [5] = '{1, 2, 3, 4, 0};
  int c0;

  initial begin
    tick(1);
    checking = 1;
    tick(2);
    chk("reset_values", 32'(values), 32'd0);
    chk("reset_sel", 32'(selector_val), 32'd0);
    chk("reset_state", 32'(button_state), 32'd0);
    rst = 1'b0;
    tick(1);

    // Selector wraps both ways.
    tap(1, 2);
    chk("sel_down_wrap", 32'(selector_val), 32'd4);
    tap(0, 2);
    tap(0, 2);
    chk("sel_up_wrap", 32'(selector_val), 32'd1);

    // Entry 3 (max 4): five single up steps, then commit.
    tap(0, 2);
    tap(0, 2);
    tap(2, 2);
    chk("edit_entry", 32'(editing), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tap(0, 1);
      chk("step_e3", 32'(staged_val), 32'(seq3[k]));
    end
    c0 = commits;
    tap(3, 2);
    chk("commit_once", 32'(commits - c0), 32'd1);
    chk("values3_after_set", 32'(values[11:9]), 32'd0);
    chk("editing_after_set", 32'(editing), 32'd0);

    // Entry 0 (max 3): hold up for 21 cycles -> steps at 0,8,12,16,20.
    tap(1, 2);
    tap(1, 2);
    tap(1, 2);
    tap(2, 2);
    b_up = 1'b1;
    tick(21);
    b_up = 1'b0;
    tick(2);
    chk("hold_repeat_staged", 32'(staged_val), 32'd1);
    tap(3, 2);
    chk("values0_after_set", 32'(values[2:0]), 32'd1);

    // Entry 4: edit, one step, then idle into the timeout.
    tap(1, 2);
    tap(2, 2);
    tap(0, 1);
    chk("staged_e4", 32'(staged_val), 32'd1);
    c0 = commits;
    tick(55);
    chk("timeout_editing", 32'(editing), 32'd0);
    chk("timeout_values4", 32'(values[14:12]), 32'd0);
    chk("timeout_no_commit", 32'(commits - c0), 32'd0);

    // up and next together in browse: up wins.
    b_up = 1'b1;
    b_next = 1'b1;
    tick(2);
    chk("combo_hold_state", 32'(button_state), 32'd1);
    b_up = 1'b0;
    b_next = 1'b0;
    tick(2);
    chk("combo_sel", 32'(selector_val), 32'd0);
    chk("combo_editing", 32'(editing), 32'd0);

    // Cancel with next: committed value stays.
    tap(2, 2);
    tap(0, 1);
    chk("cancel_staged", 32'(staged_val), 32'd2);
    tap(2, 2);
    chk("cancel_editing", 32'(editing), 32'd0);
    chk("cancel_values0", 32'(values[2:0]), 32'd1);

    // Reset in the middle of an auto-repeat hold.
    tap(2, 2);
    b_up = 1'b1;
    tick(4);
    chk("pre_reset_state", 32'(button_state), 32'd3);
    rst = 1'b1;
    tick(1);
    chk("rst_values", 32'(values), 32'd0);
    chk("rst_staged", 32'(staged_val), 32'd0);
    chk("rst_editing", 32'(editing), 32'd0);
    chk("rst_state", 32'(button_state), 32'd0);
    b_up = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
